// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampled 8N1 UART receiver with valid/ready output.
// Optional even-parity check: define UART_RX_PARITY_CHECK_EN.
`timescale 1ns/1ps
module uart_rx_os #(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
`ifdef UART_RX_PARITY_CHECK_EN
        S_PARITY  = 3'd3,
`endif
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;
    logic            r_rx_meta;
    logic            r_rx_s;
    logic [SW-1:0]   r_sc;
    logic [2:0]      r_bc;
    logic [7:0]      r_shift;
    logic            r_valid;
    logic [7:0]      r_data;
    logic            r_frame_err;
    logic            r_overrun;
    logic            w_sc_half;
    logic            w_sc_full;
    logic            w_sc_clr;
    logic            w_sc_inc;
    logic            w_bc_clr;
    logic            w_bc_inc;
    logic            w_shift;
    logic            w_complete;
    logic            w_ferr;
    logic            w_load;
`ifdef UART_RX_PARITY_CHECK_EN
    logic            w_par_smp;
    logic            r_par_bit;
    logic            r_parity_err;
`endif

    assign w_tick    = (r_tick_cnt == TW'(DIV - 1));
    assign w_sc_half = (r_sc == SW'(OVERSAMPLE / 2 - 1));
    assign w_sc_full = (r_sc == SW'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) r_tick_cnt <= '0;
        else               r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sc_clr     = 1'b0;
        w_sc_inc     = 1'b0;
        w_bc_clr     = 1'b0;
        w_bc_inc     = 1'b0;
        w_shift      = 1'b0;
        w_complete   = 1'b0;
        w_ferr       = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
        w_par_smp    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_sc_clr     = 1'b1;
                    w_state_next = S_START;
                end
            end
            // Half-bit check rejects glitches and centres all later samples.
            S_START: begin
                if (w_tick) begin
                    if (w_sc_half) begin
                        if (!r_rx_s) begin
                            w_sc_clr     = 1'b1;
                            w_bc_clr     = 1'b1;
                            w_state_next = S_DATA;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_sc_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (w_sc_full) begin
                        w_shift  = 1'b1;
                        w_sc_clr = 1'b1;
                        if (r_bc == 3'd7) begin
`ifdef UART_RX_PARITY_CHECK_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end else begin
                            w_bc_inc = 1'b1;
                        end
                    end else begin
                        w_sc_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_CHECK_EN
            S_PARITY: begin
                if (w_tick) begin
                    if (w_sc_full) begin
                        w_par_smp    = 1'b1;
                        w_sc_clr     = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_sc_inc = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (w_sc_full) begin
                        w_sc_clr = 1'b1;
                        if (r_rx_s) begin
                            w_complete   = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_ferr       = 1'b1;
                            w_state_next = S_WAIT_HI;
                        end
                    end else begin
                        w_sc_inc = 1'b1;
                    end
                end
            end
            // A held-low line (break) must return high before a new frame.
            S_WAIT_HI: begin
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sc    <= '0;
            r_bc    <= '0;
            r_shift <= '0;
        end else begin
            if (w_sc_clr)      r_sc <= '0;
            else if (w_sc_inc) r_sc <= r_sc + SW'(1);
            if (w_bc_clr)      r_bc <= '0;
            else if (w_bc_inc) r_bc <= r_bc + 3'd1;
            if (w_shift)       r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    assign w_load = w_complete && (!r_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_complete && r_valid && !rx_ready;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (!w_complete && r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (w_par_smp) r_par_bit <= r_rx_s;
            r_parity_err <= w_load && (^{r_shift, r_par_bit});
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_valid  = r_valid;
    assign rx_data   = r_data;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed bench for uart_rx_os with an expected-event model.
`timescale 1ns/1ps
module tb_uart_rx_os;
    localparam int BIT    = 160;
    localparam int K_NONE = 0;
    localparam int K_BYTE = 1;
    localparam int K_FERR = 2;
    localparam int K_OVR  = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       perr;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int  n_cmp = 0;
    int  n_err = 0;
    ev_t exp_q[$];

    uart_rx_os #(
        .CLK_FREQ   (1600000),
        .BAUD_RATE  (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic [7:0] d, input logic pe);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.perr = pe;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] d);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_data(d);
`ifdef UART_RX_PARITY_CHECK_EN
        drive(^d, BIT);
`endif
        drive(stop_b, BIT);
    endtask

`ifdef UART_RX_PARITY_CHECK_EN
    task automatic send_frame_par(input logic [7:0] d, input logic p);
        send_data(d);
        drive(p, BIT);
        drive(1'b1, BIT);
    endtask
`endif

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'(0));
    endtask

    // Event monitor: every observable output event must match the next expected one.
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b1;
    logic       p_ferr  = 1'b0;
    logic       p_ovr   = 1'b0;
    logic [7:0] p_data  = 8'h00;

    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (rst) begin
            p_valid = 1'b0;
            p_ferr  = 1'b0;
            p_ovr   = 1'b0;
        end else begin
            if (rx_valid && !p_valid) begin
                k = (exp_q.size() > 0) ? exp_q[0].kind : K_NONE;
                chk("valid_event_kind", 32'(k), 32'(K_BYTE));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e.data));
                    chk("parity_err_at_valid", 32'(parity_err), 32'(e.perr));
                end
            end else begin
                chk("parity_err_quiet", 32'(parity_err), 32'(0));
            end
            if (p_valid && p_ready) chk("accept_clears_valid", 32'(rx_valid), 32'(0));
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(rx_valid), 32'(1));
                chk("hold_data", 32'(rx_data), 32'(p_data));
            end
            if (frame_err) begin
                k = (exp_q.size() > 0) ? exp_q[0].kind : K_NONE;
                chk("frame_err_event_kind", 32'(k), 32'(K_FERR));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                chk("frame_err_width", 32'(p_ferr), 32'(0));
            end
            if (overrun) begin
                k = (exp_q.size() > 0) ? exp_q[0].kind : K_NONE;
                chk("overrun_event_kind", 32'(k), 32'(K_OVR));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                chk("overrun_width", 32'(p_ovr), 32'(0));
            end
            p_valid = rx_valid;
            p_ferr  = frame_err;
            p_ovr   = overrun;
        end
        p_ready = rx_ready;
        p_data  = rx_data;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_valid"},   32'(rx_valid),   32'(0));
        chk({tag, "_rx_data"},    32'(rx_data),    32'(0));
        chk({tag, "_frame_err"},  32'(frame_err),  32'(0));
        chk({tag, "_overrun"},    32'(overrun),    32'(0));
        chk({tag, "_parity_err"}, 32'(parity_err), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx       = 1'b1;
        rx_ready = 1'b1;
        rst      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("reset");
        drive(1'b1, 200);

        // 1: plain byte, one-cycle valid with ready high
        expect_ev(K_BYTE, 8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1);
        wait_drain(400);
        chk("t1_data", 32'(rx_data), 32'h0000_00A5);
        chk("t1_valid_dropped", 32'(rx_valid), 32'(0));
        drive(1'b1, 100);

        // 2: 40-clk glitch is shorter than half a bit
        drive(1'b0, 40);
        drive(1'b1, 200);
        chk("t2_no_valid_after_glitch", 32'(rx_valid), 32'(0));
        expect_ev(K_BYTE, 8'h3C, 1'b0);
        send_frame(8'h3C, 1'b1);
        wait_drain(400);
        chk("t2_data", 32'(rx_data), 32'h0000_003C);
        drive(1'b1, 100);

        // 3: framing error then break, recovery
        expect_ev(K_FERR, 8'h00, 1'b0);
        send_frame(8'h55, 1'b0);
        drive(1'b0, 320);
        chk("t3_no_valid", 32'(rx_valid), 32'(0));
        drive(1'b1, 200);
        wait_drain(400);
        expect_ev(K_BYTE, 8'h0F, 1'b0);
        send_frame(8'h0F, 1'b1);
        wait_drain(400);
        chk("t3_data", 32'(rx_data), 32'h0000_000F);
        drive(1'b1, 100);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        expect_ev(K_BYTE, 8'h11, 1'b0);
        expect_ev(K_OVR, 8'h00, 1'b0);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_drain(400);
        chk("t4_valid_held", 32'(rx_valid), 32'(1));
        chk("t4_data_kept", 32'(rx_data), 32'h0000_0011);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_valid_dropped", 32'(rx_valid), 32'(0));
        drive(1'b1, 100);

        // 5: reset in the middle of data bit 4 of 0xFF
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'b1, BIT);
        drive(1'b1, 80);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_all_zero("t5_after_rst");
        drive(1'b1, 80 + 4 * BIT + 200);
        chk("t5_no_valid", 32'(rx_valid), 32'(0));
        expect_ev(K_BYTE, 8'h81, 1'b0);
        send_frame(8'h81, 1'b1);
        wait_drain(400);
        chk("t5_data", 32'(rx_data), 32'h0000_0081);
        drive(1'b1, 100);

`ifdef UART_RX_PARITY_CHECK_EN
        // 6: wrong and right even parity for 0x07
        expect_ev(K_BYTE, 8'h07, 1'b1);
        send_frame_par(8'h07, 1'b0);
        wait_drain(400);
        chk("t6_bad_par_data", 32'(rx_data), 32'h0000_0007);
        drive(1'b1, 100);
        expect_ev(K_BYTE, 8'h07, 1'b0);
        send_frame_par(8'h07, 1'b1);
        wait_drain(400);
        chk("t6_good_par_data", 32'(rx_data), 32'h0000_0007);
        drive(1'b1, 100);
`endif

        chk("end_pending_events", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- UART receiver with oversampled mid-bit sampling, for the receive end of the team's 8N1 UART link.
- Synchronises the asynchronous rx line and rejects start-bit glitches.
- Detects framing errors and optionally parity errors.
- Presents each received byte on a valid/ready handshake with overrun reporting.
- Runs entirely on clk; there is no derived clock domain.

Parameters:
- CLK_FREQ, 1000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bit/s.
- OVERSAMPLE, 16: sample ticks per bit; must be even and at least 4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_ready  input  1  consumer accepts the byte when rx_ready and rx_valid are both high.
- rx_valid  output  1  received byte available; held until accepted.
- rx_data  output  8  received byte, LSB first on the line; stable while rx_valid is high.
- frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a byte completes while the previous byte is still unaccepted.
- parity_err  output  1  one-cycle parity-mismatch pulse; tied 0 when the optional feature is off.

Behaviour:
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, with a minimum of 1.
  - Free-running counter 0..DIV-1; a 1-cycle tick fires when it wraps.
  - Counter is cleared by rst.
- Synchroniser: 2-FF synchroniser on rx; both flops reset to 1. rx_s is the synchronised line.
- Sample counter sc: counts ticks within a bit, 0..OVERSAMPLE-1. Bit counter bc: 0..7.
- FSM states are IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HI.
  - IDLE: when rx_s==0 on any clk, clear sc and go to START.
  - START: on ticks, increment sc. At sc==OVERSAMPLE/2-1:
    - if rx_s==0: clear sc, clear bc, go to DATA;
    - else: false start, return to IDLE with no outputs.
  - DATA: on ticks, increment sc. At sc==OVERSAMPLE-1:
    - shift rx_s into the MSB of the shift register (right shift);
    - clear sc;
    - if bc==7 go to PARITY or STOP, else increment bc.
  - PARITY: at sc==OVERSAMPLE-1, sample the parity bit, clear sc, go to STOP.
  - STOP: at sc==OVERSAMPLE-1, sample the stop bit.
    - If it is 1: complete the byte and go to IDLE. Back-to-back frames are supported.
    - If it is 0: pulse frame_err, discard the byte, go to WAIT_HI.
  - WAIT_HI: stay until rx_s==1, then go to IDLE. A break condition never produces repeated frames.
- Sampling point: data, parity and stop samples fall at the bit centre, OVERSAMPLE ticks after the previous centre.
- Output handshake:
  - Completion registers on the clk edge of the stop-sample tick; rx_valid is visible the next cycle.
  - Completion with rx_valid==0: load rx_data, set rx_valid.
  - Acceptance (rx_valid and rx_ready) without a completion in the same cycle: clear rx_valid; rx_data holds its last value.
  - Completion with rx_valid==1 and rx_ready==1 in the same cycle: load the new byte; rx_valid stays 1; no overrun.
  - Completion with rx_valid==1 and rx_ready==0: pulse overrun, drop the new byte, keep the old one.
- Error pulses: frame_err, overrun and parity_err are each exactly 1 cycle wide and registered.
- Reset, including mid-frame:
  - state IDLE, sc=0, bc=0, shift register 0;
  - rx_valid=0, rx_data=0x00, frame_err=0, overrun=0, parity_err=0.
  - Any partial frame is abandoned.

Optional Feature:
- Macro: UART_RX_PARITY_CHECK_EN.
- When defined:
  - frame is start + 8 data + even-parity bit + stop;
  - PARITY state is present;
  - a mismatch (XOR of the 8 data bits and the parity bit is not 0) pulses parity_err in the same cycle rx_valid asserts;
  - the byte is still delivered.
- When undefined:
  - no PARITY state; the 8N1 frame goes directly from DATA to STOP;
  - parity_err is constant 0.

Test Plan:
Bench setting for all scenarios: CLK_FREQ=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving DIV=10, 160 clk per bit, rx_ready=1 unless stated.
1. Send 0xA5 8N1 -> rx_valid high for exactly 1 cycle, rx_data=0xA5, no error pulses.
2. rx low for 40 clk, then high; then send 0x3C -> no rx_valid for the glitch; rx_data=0x3C afterwards with no errors.
3. Send 0x55 with stop bit 0, hold rx low for 320 clk, release, then send 0x0F -> one frame_err pulse, no rx_valid for 0x55, no activity while low, then rx_data=0x0F.
4. rx_ready=0; send 0x11 then 0x22 back-to-back -> rx_valid held with 0x11; one overrun pulse at 0x22 completion; rx_data stays 0x11. Then raise rx_ready -> rx_valid drops the next cycle.
5. Send 0xFF and assert rst for 1 cycle during data bit 4 -> all outputs 0 the next cycle; a following 0x81 is received correctly.
6. With UART_RX_PARITY_CHECK_EN: send 0x07 with parity bit 0 (correct value is 1) -> rx_data=0x07, parity_err pulses coincident with the rx_valid rise. Send 0x07 with parity 1 -> no parity_err.
